rand_server: RTL and testbench
==============================

Name: rand_server

Overview:
- Shares one 64-bit Galois LFSR random source among NUM_REQ requesters.
- Round-robin arbitration, with at most one grant per cycle.
- Each grant returns one WIDTH-bit random word and advances the LFSR by exactly one step.
- Supports runtime reseed and a warm-up phase after reset or reseed, so test benches and stimulus generators get reproducible, non-overlapping random streams.

Parameters:
- NUM_REQ, 4: number of requesters; 2..16.
- WIDTH, 32: random word width; 1..64.
- WARMUP, 8: LFSR steps run after reset or reseed before any grant; 0..255.
- SEED, 64'h0c45f864_04e4684a: default seed, also substituted for an all-zero reseed value.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- req_i, in, NUM_REQ: level request per requester.
- gnt_o, out, NUM_REQ: one-hot grant pulse, registered.
- rand_valid_o, out, 1: high whenever gnt_o != 0.
- rand_data_o, out, WIDTH: random word for the granted requester; valid with rand_valid_o.
- reseed_i, in, 1: load reseed_data_i this cycle.
- reseed_data_i, in, 64: new seed.
- busy_o, out, 1: high during warm-up (state WARM).

Behaviour:
- LFSR step, next(x):
  - {x[62:0],1'b0} ^ ({64{x[63]}} & 64'h1B).
  - The LFSR never holds zero.
- FSM states: WARM, RUN.
- Reset (synchronous, highest priority):
  - lfsr_q=SEED, state=WARM, warm_cnt=0, rr_ptr=0.
  - gnt_o=0, rand_valid_o=0, rand_data_o=0, busy_o=1.
  - If WARMUP=0, reset goes directly to RUN with busy_o=0.
- WARM:
  - lfsr_q<=next(lfsr_q) and warm_cnt++ every cycle.
  - Requests are ignored; no grant.
  - When warm_cnt==WARMUP-1, go to RUN on that edge.
  - busy_o is registered and equals (state==WARM).
- RUN:
  - If any req_i bit is set, the winner is the first set bit searching upward, with wrap, from rr_ptr.
  - On the edge: gnt_o<=onehot(winner), rand_data_o<=lfsr_q[WIDTH-1:0], lfsr_q<=next(lfsr_q), rr_ptr<=(winner+1) mod NUM_REQ.
  - With no request: gnt_o<=0, and lfsr_q and rr_ptr are held. rand_data_o holds its last value, which is don't-care when invalid.
  - Latency: request sampled at edge t gives its grant in cycle t+1.
  - A requester keeping req high receives one word per grant. Under full load, all requesters are served in strict rotation, one word per cycle.
- Reseed (priority below reset, above arbitration):
  - In any state: lfsr_q<=(reseed_data_i==0 ? SEED : reseed_data_i), warm_cnt<=0, state<=WARM (RUN if WARMUP=0), gnt_o<=0.
  - rr_ptr is preserved.
  - Requests in the reseed cycle are not granted.
  - Reseed during WARM restarts warm-up.
- Simultaneous reseed and reset: reset wins.
- Requests asserted at the same edge as the WARM->RUN transition are not granted; the first grant-capable edge is the next one.
- Invariant: gnt_o is zero or one-hot, and gnt_o never has a bit set whose req_i was low at the sampling edge.

Decomposition:
- Package rand_pkg holds:
  - LFSR_WIDTH=64, LFSR_POLY=64'h1B, DEFAULT_SEED.
  - The state enum typedef {WARM, RUN}.
  - The lfsr_next function.
- One sub-module, rr_arbiter: combinational round-robin picker with inputs req and ptr, and outputs onehot and index.
- The LFSR, FSM and output registers stay in rand_server.

Test Plan:
- Reset, WARMUP=0, req_i=4'b0001 held:
  - gnt_o=0001 from the cycle after reset deasserts.
  - rand_data_o: 0x04e4684a, then 0x09c8d094, 0x1391a128 (32-bit low words of successive steps).
- WARMUP=8, request held from reset:
  - busy_o=1 for 8 cycles.
  - The first grant appears exactly 1 cycle after busy_o falls.
  - The first word equals the low 32 bits of next^8(SEED).
- reseed_i with 64'h1, WARMUP=0, req_i=4'b1111 held:
  - Grants rotate 0001, 0010, 0100, 1000, 0001.
  - Data: 0x1, 0x2, 0x4, 0x8, 0x10.
- Reseed with 64'h8000_0000_0000_0000, WARMUP=0, one request:
  - Data 0x00000000 (low bits of seed), then 0x0000001B.
- Reseed with 0, WARMUP=0:
  - Same stream as after reset: first word 0x04e4684a.
- Reseed asserted mid-stream while req_i=4'b0110:
  - No grant in the reseed cycle; rr_ptr is kept.
  - After reseed, the next grant goes to the requester after the last one served.
- Reset asserted together with reseed_i=1:
  - The reset state results and SEED is loaded, not reseed_data_i.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared types and the LFSR step function for the random-number server.
package rand_pkg;

  localparam int          LFSR_WIDTH   = 64;
  localparam logic [63:0] LFSR_POLY    = 64'h1B;
  localparam logic [63:0] DEFAULT_SEED = 64'h0c45f864_04e4684a;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One Galois step; a nonzero state never maps to zero.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] x);
    return {x[LFSR_WIDTH-2:0], 1'b0} ^ ({LFSR_WIDTH{x[LFSR_WIDTH-1]}} & LFSR_POLY);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        index        = cand;
      end
    end
  end

endmodule

// File: rtl/rand_server.sv
// Round-robin server handing out words from one shared 64-bit Galois LFSR.
//   state | meaning
//   WARM  | LFSR free-runs WARMUP steps after reset/reseed; requests ignored
//   RUN   | one grant per cycle, each grant consumes one LFSR step
module rand_server
  import rand_pkg::*;
#(
  parameter int          NUM_REQ = 4,
  parameter int          WIDTH   = 32,
  parameter int          WARMUP  = 8,
  parameter logic [63:0] SEED    = DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               rand_valid_o,
  output logic [WIDTH-1:0]   rand_data_o,
  input  logic               reseed_i,
  input  logic [63:0]        reseed_data_i,
  output logic               busy_o
);

  localparam int         IW        = $clog2(NUM_REQ);
  localparam state_t     START     = (WARMUP == 0) ? RUN : WARM;
  localparam logic [7:0] WARM_LAST = 8'((WARMUP == 0) ? 0 : WARMUP - 1);

  state_t             state_q, state_d;
  logic [63:0]        lfsr_q, lfsr_d;
  logic [7:0]         warm_cnt_q, warm_cnt_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d, win_idx;
  logic [NUM_REQ-1:0] win_onehot, gnt_d;
  logic [WIDTH-1:0]   data_d;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req    (req_i),
    .ptr    (rr_ptr_q),
    .onehot (win_onehot),
    .index  (win_idx)
  );

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    warm_cnt_d = warm_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = '0;
    data_d     = rand_data_o;
    if (reseed_i) begin
      // An all-zero seed would lock the LFSR, so fall back to the default.
      lfsr_d     = (reseed_data_i == '0) ? SEED : reseed_data_i;
      warm_cnt_d = '0;
      state_d    = START;
    end else begin
      case (state_q)
        WARM: begin
          lfsr_d     = lfsr_next(lfsr_q);
          warm_cnt_d = warm_cnt_q + 8'd1;
          if (warm_cnt_q == WARM_LAST) state_d = RUN;
        end
        RUN: begin
          if (|req_i) begin
            gnt_d    = win_onehot;
            data_d   = lfsr_q[WIDTH-1:0];
            lfsr_d   = lfsr_next(lfsr_q);
            rr_ptr_d = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= START;
      lfsr_q      <= SEED;
      warm_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      gnt_o       <= '0;
      rand_data_o <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      warm_cnt_q  <= warm_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_o       <= gnt_d;
      rand_data_o <= data_d;
    end
  end

  assign rand_valid_o = |gnt_o;
  assign busy_o       = (state_q == WARM);

endmodule

// File: tb/tb_rand_server.sv
// Bench for rand_server: directed scenarios plus randomized traffic against a
// cycle-level reference model, on a WARMUP=0 and a WARMUP=8 instance.
module tb_rand_server;

  localparam logic [63:0] SEED = 64'h0c45f864_04e4684a;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req0 = '0, req8 = '0;
  logic        reseed0 = 1'b0, reseed8 = 1'b0;
  logic [63:0] rd0 = '0, rd8 = '0;
  logic [3:0]  gnt0, gnt8;
  logic        valid0, valid8, busy0, busy8;
  logic [31:0] data0, data8;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rand_server #(.NUM_REQ(4), .WIDTH(32), .WARMUP(0)) dut0 (
    .clk(clk), .reset(reset), .req_i(req0), .gnt_o(gnt0), .rand_valid_o(valid0),
    .rand_data_o(data0), .reseed_i(reseed0), .reseed_data_i(rd0), .busy_o(busy0)
  );

  rand_server #(.NUM_REQ(4), .WIDTH(32), .WARMUP(8)) dut8 (
    .clk(clk), .reset(reset), .req_i(req8), .gnt_o(gnt8), .rand_valid_o(valid8),
    .rand_data_o(data8), .reseed_i(reseed8), .reseed_data_i(rd8), .busy_o(busy8)
  );

  // Reference model: [0] mirrors dut0, [1] mirrors dut8.
  logic [63:0] m_lfsr[2];
  int          m_warm[2];
  int          m_ptr[2];
  logic [3:0]  m_gnt[2];
  logic [31:0] m_data[2];
  logic [3:0]  m_req_seen[2];

  function automatic logic [63:0] step(input logic [63:0] x);
    logic [63:0] y;
    y = x << 1;
    if (x[63]) y = y ^ 64'h1B;
    return y;
  endfunction

  task automatic model_edge(input int k, input int warmup, input logic rs, input logic sd,
                            input logic [63:0] d, input logic [3:0] rq);
    bit found;
    int win;
    m_gnt[k]      = '0;
    m_req_seen[k] = rq;
    if (rs) begin
      m_lfsr[k] = SEED;
      m_warm[k] = warmup;
      m_ptr[k]  = 0;
      m_data[k] = '0;
    end else if (sd) begin
      m_lfsr[k] = (d == 64'd0) ? SEED : d;
      m_warm[k] = warmup;
    end else if (m_warm[k] > 0) begin
      m_lfsr[k] = step(m_lfsr[k]);
      m_warm[k] = m_warm[k] - 1;
    end else if (rq != 4'd0) begin
      found = 0;
      win   = 0;
      for (int j = 0; j < 4; j++) begin
        if (!found && rq[(m_ptr[k] + j) % 4]) begin
          found = 1;
          win   = (m_ptr[k] + j) % 4;
        end
      end
      m_gnt[k]  = 4'(1 << win);
      m_data[k] = m_lfsr[k][31:0];
      m_lfsr[k] = step(m_lfsr[k]);
      m_ptr[k]  = (win + 1) % 4;
    end
  endtask

  always @(posedge clk) begin
    model_edge(0, 0, reset, reseed0, rd0, req0);
    model_edge(1, 8, reset, reseed8, rd8, req8);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0  = 4'hF;
    req8  = 4'hF;
    tick(); tick();
    tests++; if (gnt0 !== 4'd0) begin errors++; $display("FAIL reset_gnt0 got %b exp 0000", gnt0); end
    tests++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid0 got %b exp 0", valid0); end
    tests++; if (data0 !== 32'd0) begin errors++; $display("FAIL reset_data0 got %h exp 0", data0); end
    tests++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0 got %b exp 0", busy0); end
    tests++; if (busy8 !== 1'b1) begin errors++; $display("FAIL reset_busy8 got %b exp 1", busy8); end
    tests++; if (gnt8 !== 4'd0) begin errors++; $display("FAIL reset_gnt8 got %b exp 0000", gnt8); end
    req0 = '0;
    req8 = '0;
  endtask

  task automatic test_warmup0_stream();
    logic [31:0] exp_d[3];
    exp_d[0] = 32'h04e4684a;
    exp_d[1] = 32'h09c8d094;
    exp_d[2] = 32'h1391a128;
    reset = 1'b1;
    req0  = 4'b0001;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (gnt0 !== 4'b0001) begin errors++; $display("FAIL w0_gnt[%0d] got %b exp 0001", i, gnt0); end
      tests++; if (data0 !== exp_d[i]) begin errors++; $display("FAIL w0_data[%0d] got %h exp %h", i, data0, exp_d[i]); end
    end
    req0 = '0;
  endtask

  task automatic test_warmup8();
    logic [63:0] e;
    int busy_cycles;
    int guard;
    e = SEED;
    for (int i = 0; i < 8; i++) e = step(e);
    reset = 1'b1;
    req8  = 4'b0001;
    tick();
    reset = 1'b0;
    busy_cycles = 0;
    guard = 0;
    while (busy8 === 1'b1 && guard < 40) begin
      tests++; if (gnt8 !== 4'd0) begin errors++; $display("FAIL w8_gnt_in_warm got %b exp 0000", gnt8); end
      busy_cycles++;
      guard++;
      tick();
    end
    tests++; if (busy_cycles != 8) begin errors++; $display("FAIL w8_busy_len got %0d exp 8", busy_cycles); end
    tests++; if (gnt8 !== 4'd0) begin errors++; $display("FAIL w8_gnt_at_run got %b exp 0000", gnt8); end
    tick();
    tests++; if (gnt8 !== 4'b0001) begin errors++; $display("FAIL w8_first_gnt got %b exp 0001", gnt8); end
    tests++; if (data8 !== e[31:0]) begin errors++; $display("FAIL w8_first_data got %h exp %h", data8, e[31:0]); end
    req8 = '0;
  endtask

  task automatic test_reseed_one();
    logic [3:0] exp_g[5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    reset = 1'b1;
    req0  = '0;
    tick();
    reset   = 1'b0;
    reseed0 = 1'b1;
    rd0     = 64'h1;
    req0    = 4'hF;
    tick();
    tests++; if (gnt0 !== 4'd0) begin errors++; $display("FAIL rs1_gnt_in_reseed got %b exp 0000", gnt0); end
    reseed0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (gnt0 !== exp_g[i]) begin errors++; $display("FAIL rs1_gnt[%0d] got %b exp %b", i, gnt0, exp_g[i]); end
      tests++; if (data0 !== 32'(1 << i)) begin errors++; $display("FAIL rs1_data[%0d] got %h exp %h", i, data0, 32'(1 << i)); end
    end
    req0 = '0;
  endtask

  task automatic test_reseed_msb();
    reseed0 = 1'b1;
    rd0     = 64'h8000_0000_0000_0000;
    req0    = 4'b0001;
    tick();
    reseed0 = 1'b0;
    tick();
    tests++; if (valid0 !== 1'b1 || data0 !== 32'h0) begin errors++; $display("FAIL msb_data0 got %h valid %b exp 00000000", data0, valid0); end
    tick();
    tests++; if (data0 !== 32'h1B) begin errors++; $display("FAIL msb_data1 got %h exp 0000001b", data0); end
    req0 = '0;
  endtask

  task automatic test_reseed_zero();
    reseed0 = 1'b1;
    rd0     = 64'h0;
    req0    = 4'b0100;
    tick();
    reseed0 = 1'b0;
    tick();
    tests++; if (data0 !== 32'h04e4684a) begin errors++; $display("FAIL zero_seed_data got %h exp 04e4684a", data0); end
    req0 = '0;
  endtask

  task automatic test_reseed_mid();
    logic [3:0] exp_g[3];
    exp_g[0] = 4'b0010; exp_g[1] = 4'b0100; exp_g[2] = 4'b0010;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0  = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (gnt0 !== exp_g[i]) begin errors++; $display("FAIL mid_gnt[%0d] got %b exp %b", i, gnt0, exp_g[i]); end
    end
    reseed0 = 1'b1;
    rd0     = {$urandom, $urandom} | 64'h1;
    tick();
    tests++; if (gnt0 !== 4'd0) begin errors++; $display("FAIL mid_gnt_in_reseed got %b exp 0000", gnt0); end
    reseed0 = 1'b0;
    tick();
    tests++; if (gnt0 !== 4'b0100) begin errors++; $display("FAIL mid_gnt_after_reseed got %b exp 0100", gnt0); end
    tick();
    tests++; if (gnt0 !== 4'b0010) begin errors++; $display("FAIL mid_gnt_after_reseed2 got %b exp 0010", gnt0); end
    req0 = '0;
  endtask

  task automatic test_reset_reseed();
    req0 = 4'b0001;
    tick(); tick();
    reset   = 1'b1;
    reseed0 = 1'b1;
    rd0     = 64'h1;
    tick();
    tests++; if (gnt0 !== 4'd0 || data0 !== 32'd0) begin errors++; $display("FAIL rr_state got gnt %b data %h exp 0000/0", gnt0, data0); end
    reset   = 1'b0;
    reseed0 = 1'b0;
    tick();
    tests++; if (data0 !== 32'h04e4684a) begin errors++; $display("FAIL rr_seed_data got %h exp 04e4684a", data0); end
    tests++; if (gnt0 !== 4'b0001) begin errors++; $display("FAIL rr_gnt got %b exp 0001", gnt0); end
    req0 = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset   = ($urandom_range(0, 99) == 0);
      reseed0 = ($urandom_range(0, 24) == 0);
      reseed8 = ($urandom_range(0, 24) == 0);
      rd0     = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      rd8     = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      req0    = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      req8    = 4'($urandom_range(0, 15));
      tick();
      tests++; if (gnt0 !== m_gnt[0] || data0 !== m_data[0] || busy0 !== (m_warm[0] > 0))
        begin errors++; $display("FAIL rnd0[%0d] got gnt %b data %h busy %b exp gnt %b data %h busy %b",
                                 c, gnt0, data0, busy0, m_gnt[0], m_data[0], m_warm[0] > 0); end
      tests++; if (gnt8 !== m_gnt[1] || data8 !== m_data[1] || busy8 !== (m_warm[1] > 0))
        begin errors++; $display("FAIL rnd8[%0d] got gnt %b data %h busy %b exp gnt %b data %h busy %b",
                                 c, gnt8, data8, busy8, m_gnt[1], m_data[1], m_warm[1] > 0); end
      tests++; if (!$onehot0(gnt0) || (gnt0 & ~m_req_seen[0]) != 4'd0 || valid0 !== (gnt0 != 4'd0))
        begin errors++; $display("FAIL rnd0_inv[%0d] got gnt %b valid %b req %b exp onehot subset", c, gnt0, valid0, m_req_seen[0]); end
      tests++; if (!$onehot0(gnt8) || (gnt8 & ~m_req_seen[1]) != 4'd0 || valid8 !== (gnt8 != 4'd0))
        begin errors++; $display("FAIL rnd8_inv[%0d] got gnt %b valid %b req %b exp onehot subset", c, gnt8, valid8, m_req_seen[1]); end
    end
    reset   = 1'b0;
    reseed0 = 1'b0;
    reseed8 = 1'b0;
    req0    = '0;
    req8    = '0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_warmup0_stream();
    test_warmup8();
    test_reseed_one();
    test_reseed_msb();
    test_reseed_zero();
    test_reseed_mid();
    test_reset_reseed();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
